gray_convert: RTL and testbench

Grayscale conversion stage directly downstream of the 32-bit-word pixel unpacker. It accepts one group of four 24-bit RGB pixels per `gray_en` pulse and converts each pixel to an 8-bit luma value through a two-stage pipeline. It packs the four luma bytes into one 32-bit word and presents it to the memory-write side through a 2-entry output buffer with a valid/ready handshake. It also counts emitted words per frame and flags the end of the frame.

---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray_fifo.sv | 67 ++++++
 rtl/gray_convert.sv | 142 ++++++++++++++
 tb/tb_gray_convert.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and constants for the grayscale conversion stage.
// Luma weights are 8-bit fixed point and sum to 256, so white maps to 255.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } grayStateType;

  localparam int COEF_R            = 77;
  localparam int COEF_G            = 150;
  localparam int COEF_B            = 29;
  localparam int ROUND             = 128;
  localparam int PIX_PER_WORD      = 4;
  localparam int GROUP_CNT_DEFAULT = 76800;

  // The largest possible sum is 65408, so 16 bits never wrap.
  function automatic logic [7:0] luma_round(input logic [15:0] pr,
                                            input logic [15:0] pg,
                                            input logic [15:0] pb);
    logic [15:0] sum;
    sum = pr + pg + pb + 16'(ROUND);
    return sum[15:8];
  endfunction

endpackage

// File: rtl/gray_fifo.sv
// Two-entry synchronous FIFO; the head entry is always visible on rd_data.
// A write into a full FIFO only lands when a read frees a slot in the same cycle.
module gray_fifo
  import gray_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   cnt_reg;
  logic [1:0]   cnt_next;
  logic         do_wr;
  logic         do_rd;

  assign full    = (cnt_reg == 2'd2);
  assign empty   = (cnt_reg == 2'd0);
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem_reg[rd_ptr_reg];

  always_comb begin
    cnt_next = cnt_reg;
    case ({do_wr, do_rd})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      if (do_wr) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_rd) rd_ptr_reg <= ~rd_ptr_reg;
      cnt_reg <= cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (do_wr && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/gray_convert.sv
// RGB-to-luma stage: four pixels per group, products registered in stage 1,
// rounded sums written straight into a 2-entry output FIFO, with per-frame word counting.
module gray_convert
  import gray_pkg::*;
#(
  parameter int GROUP_CNT = GROUP_CNT_DEFAULT,
  parameter int CNT_W     = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_en,
  input  logic [3:0][23:0]      in_pixels,
  input  logic                  gray_en,
  input  logic                  out_ready,
  output logic [31:0]           gray_word,
  output logic                  gray_valid,
  output logic [CNT_W-1:0]      word_count,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(GROUP_CNT - 1);

  grayStateType     state_reg;
  grayStateType     state_next;
  logic [15:0]      prod_r_reg [PIX_PER_WORD];
  logic [15:0]      prod_g_reg [PIX_PER_WORD];
  logic [15:0]      prod_b_reg [PIX_PER_WORD];
  logic [7:0]       luma       [PIX_PER_WORD];
  logic [31:0]      word_in;
  logic             s1_valid_reg;
  logic [CNT_W-1:0] word_count_reg;
  logic             overflow_reg;
  logic             frame_done_reg;

  logic accept;
  logic xfer;
  logic flush;
  logic clear_frame;
  logic last_xfer;
  logic fifo_wr;
  logic fifo_rd;
  logic fifo_full;
  logic fifo_empty;

  assign accept     = (state_reg == ACTIVE) && gray_en;
  assign gray_valid = !fifo_empty;
  assign xfer       = gray_valid && out_ready;
  assign fifo_rd    = xfer && !flush;
  assign fifo_wr    = s1_valid_reg && !flush;

  always_comb begin
    state_next  = state_reg;
    flush       = 1'b0;
    clear_frame = 1'b0;
    last_xfer   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_en) begin
          state_next  = ACTIVE;
          clear_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (xfer && (word_count_reg == LAST_WORD)) begin
          state_next = DONE;
          last_xfer  = 1'b1;
        end
      end
      DONE: begin
        flush      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      s1_valid_reg   <= 1'b0;
      word_count_reg <= '0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      s1_valid_reg   <= accept;
      frame_done_reg <= last_xfer;
      if (clear_frame) begin
        word_count_reg <= '0;
      end else if ((state_reg == ACTIVE) && xfer) begin
        word_count_reg <= word_count_reg + CNT_W'(1);
      end
      // Only a write that finds the FIFO full with no read alongside is lost.
      if (clear_frame) begin
        overflow_reg <= 1'b0;
      end else if (fifo_wr && fifo_full && !fifo_rd) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_pix
      always_ff @(posedge clk) begin
        if (rst) begin
          prod_r_reg[gi] <= '0;
          prod_g_reg[gi] <= '0;
          prod_b_reg[gi] <= '0;
        end else if (accept) begin
          prod_r_reg[gi] <= 16'(COEF_R) * 16'(in_pixels[gi][23:16]);
          prod_g_reg[gi] <= 16'(COEF_G) * 16'(in_pixels[gi][15:8]);
          prod_b_reg[gi] <= 16'(COEF_B) * 16'(in_pixels[gi][7:0]);
        end
      end

      assign luma[gi]           = luma_round(prod_r_reg[gi], prod_g_reg[gi], prod_b_reg[gi]);
      assign word_in[gi*8 +: 8] = luma[gi];
    end
  endgenerate

  // The FIFO entry itself serves as the stage-2 register.
  gray_fifo #(
    .W(32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr      (fifo_wr),
    .wr_data (word_in),
    .rd      (fifo_rd),
    .rd_data (gray_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign word_count = word_count_reg;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_gray_convert.sv
// Bench for gray_convert: directed scenarios plus randomized frames, all checked
// every cycle against a queue-based reference of the conversion and buffering rules.
module tb_gray_convert;

  localparam int G  = 4;
  localparam int CW = 17;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_en = 1'b0;
  logic             gray_en = 1'b0;
  logic             out_ready = 1'b0;
  logic [3:0][23:0] in_pixels = '0;
  logic [31:0]      gray_word;
  logic             gray_valid;
  logic [CW-1:0]    word_count;
  logic             frame_done;
  logic             overflow;

  int errors = 0;
  int checks = 0;
  int fd_seen = 0;
  int xfer_seen = 0;

  always #5 clk = ~clk;

  gray_convert #(
    .GROUP_CNT (G),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_en   (start_en),
    .in_pixels  (in_pixels),
    .gray_en    (gray_en),
    .out_ready  (out_ready),
    .gray_word  (gray_word),
    .gray_valid (gray_valid),
    .word_count (word_count),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [3:0][23:0] px);
    logic [31:0] w;
    int r, g, b;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      r = int'(px[i][23:16]);
      g = int'(px[i][15:8]);
      b = int'(px[i][7:0]);
      w[i*8 +: 8] = 8'((77 * r + 150 * g + 29 * b + 128) / 256);
    end
    return w;
  endfunction

  function automatic logic [3:0][23:0] rand_px();
    logic [3:0][23:0] px;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 5))
        0:       px[i] = 24'h000000;
        1:       px[i] = 24'hFFFFFF;
        default: px[i] = 24'($urandom);
      endcase
    end
    return px;
  endfunction

  // Reference: frame active/done flags, a queue of at most two buffered words,
  // and one word in flight for the cycle between acceptance and buffering.
  bit          m_active = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  bit          m_fdone = 0;
  int          m_count = 0;
  logic [31:0] m_q[$];
  bit          m_pipe_v = 0;
  logic [31:0] m_pipe_w = '0;

  initial begin
    bit rd;
    bit was_active;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 0; m_done = 0; m_ovf = 0; m_fdone = 0; m_count = 0;
        m_q.delete(); m_pipe_v = 0;
      end else if (m_done) begin
        m_q.delete(); m_pipe_v = 0; m_done = 0; m_fdone = 0;
      end else begin
        was_active = m_active;
        m_fdone = 0;
        rd = (m_q.size() > 0) && out_ready;
        if (rd) begin
          void'(m_q.pop_front());
          if (m_active) begin
            m_count++;
            if (m_count == G) begin
              m_active = 0; m_done = 1; m_fdone = 1;
            end
          end
        end
        if (m_pipe_v) begin
          if (m_q.size() < 2) m_q.push_back(m_pipe_w);
          else m_ovf = 1;
        end
        m_pipe_v = was_active && gray_en;
        m_pipe_w = ref_word(in_pixels);
        if (!was_active && start_en) begin
          m_active = 1; m_count = 0; m_ovf = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("valid", 32'(gray_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("word", gray_word, m_q[0]);
    check("count", 32'(word_count), 32'(m_count));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("frame_done", 32'(frame_done), 32'(m_fdone));
    if (frame_done) fd_seen++;
    if (gray_valid && out_ready) xfer_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_en = 1'b0; gray_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic start();
    start_en = 1'b1;
    tick();
    start_en = 1'b0;
  endtask

  task automatic pulse(input logic [3:0][23:0] px);
    in_pixels = px;
    gray_en = 1'b1;
    tick();
    gray_en = 1'b0;
  endtask

  initial begin
    logic [3:0][23:0] pa, pb, pc, pd;
    int  budget;
    int  gap;
    bit  seen;

    // Reset values
    do_reset();
    check("rst_word", gray_word, 32'h0);
    check("rst_valid", 32'(gray_valid), 32'h0);
    check("rst_count", 32'(word_count), 32'h0);
    check("rst_fdone", 32'(frame_done), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);

    // White pixels and two-cycle latency
    start();
    out_ready = 1'b1;
    pulse({4{24'hFFFFFF}});
    check("lat_early", 32'(gray_valid), 32'h0);
    tick();
    check("lat_valid", 32'(gray_valid), 32'h1);
    check("white", gray_word, 32'hFFFFFFFF);
    tick();
    check("white_count", 32'(word_count), 32'h1);

    // Pure primaries plus mid grey; G gives (150*255+128)>>8 = 149
    pulse({24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080});
    tick();
    check("primaries", gray_word, 32'h4D951D80);
    tick();
    check("prim_count", 32'(word_count), 32'h2);

    // Backpressure: two words held, third dropped
    do_reset();
    start();
    out_ready = 1'b0;
    pa = rand_px(); pb = rand_px(); pc = rand_px();
    pulse(pa); repeat (2) tick();
    pulse(pb); repeat (2) tick();
    pulse(pc); repeat (3) tick();
    check("hold_valid", 32'(gray_valid), 32'h1);
    check("hold_first", gray_word, ref_word(pa));
    check("ovf_set", 32'(overflow), 32'h1);
    out_ready = 1'b1;
    tick();
    check("drain_second", gray_word, ref_word(pb));
    check("drain_valid", 32'(gray_valid), 32'h1);
    tick();
    check("drain_empty", 32'(gray_valid), 32'h0);
    repeat (3) tick();
    check("drain_count", 32'(word_count), 32'h2);

    // Frame end with one extra group
    do_reset();
    start();
    out_ready = 1'b1;
    fd_seen = 0; xfer_seen = 0;
    for (int i = 0; i < 5; i++) begin
      pulse(rand_px());
      repeat (2) tick();
    end
    repeat (5) tick();
    check("frame_count", 32'(word_count), 32'(G));
    check("frame_pulses", 32'(fd_seen), 32'h1);
    check("frame_xfers", 32'(xfer_seen), 32'(G));
    check("frame_idle_valid", 32'(gray_valid), 32'h0);
    start();
    check("frame_restart", 32'(word_count), 32'h0);

    // gray_en ignored while idle
    do_reset();
    out_ready = 1'b1;
    xfer_seen = 0;
    pulse(rand_px()); repeat (2) tick();
    pulse(rand_px()); repeat (3) tick();
    check("idle_valid", 32'(gray_valid), 32'h0);
    check("idle_count", 32'(word_count), 32'h0);
    check("idle_xfers", 32'(xfer_seen), 32'h0);

    // Reset mid-frame with buffered and in-flight data
    do_reset();
    start();
    out_ready = 1'b1;
    pulse(rand_px()); repeat (2) tick();
    out_ready = 1'b0;
    pa = rand_px(); pb = rand_px(); pd = rand_px(); pc = rand_px();
    pulse(pa); repeat (2) tick();
    pulse(pb); repeat (2) tick();
    pulse(pd); repeat (2) tick();
    check("pre_rst_count", 32'(word_count), 32'h1);
    check("pre_rst_ovf", 32'(overflow), 32'h1);
    pulse(pc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(gray_valid), 32'h0);
    check("mid_rst_count", 32'(word_count), 32'h0);
    check("mid_rst_ovf", 32'(overflow), 32'h0);
    start();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale", 32'(gray_valid), 32'h0);
    end

    // Randomized frames with random backpressure
    for (int f = 0; f < 8; f++) begin
      start();
      seen = 0;
      budget = 0;
      while (budget < 300 && !seen) begin
        gap = int'($urandom_range(3, 5));
        in_pixels = rand_px();
        gray_en = 1'b1;
        for (int c = 0; c < gap; c++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
          gray_en = 1'b0;
          if (frame_done) seen = 1;
          budget++;
        end
      end
      check("rand_frame_end", 32'(seen), 32'h1);
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
